// File: rtl/wheel_pwm_driver.sv
// wheel_pwm_driver: soft-start / soft-stop PWM stage for the two wheel motors.
// A free-running counter forms the PWM period; duties ramp towards the
// commanded target once every RAMP_DIV periods, only at period boundaries.
module wheel_pwm_driver #(
    parameter int PWM_BITS  = 8,
    parameter int DUTY_MAX  = 200,
    parameter int RAMP_STEP = 8,
    parameter int RAMP_DIV  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] wheel_cmd,
    input  logic       estop,
    output logic       pwm_l,
    output logic       pwm_r,
    output logic [1:0] settled,
    output logic       busy
);

    localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PWM_BITS-1:0] CNT_LAST = '1;
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(RAMP_DIV - 1);
    localparam logic [PWM_BITS:0]   DMAX     = (PWM_BITS + 1)'(DUTY_MAX);
    localparam logic [PWM_BITS:0]   STEP     = (PWM_BITS + 1)'(RAMP_STEP);

    typedef enum logic [1:0] {
        IDLE,
        ACCEL,
        DECEL,
        RUN
    } wheel_state_t;

    // Index 1 = left wheel, index 0 = right wheel throughout.
    logic [PWM_BITS-1:0] r_cnt;
    logic [DIV_W-1:0]    r_div;
    logic [1:0]          r_cmd_q;
    logic [PWM_BITS:0]   r_duty [2];
    wheel_state_t        r_state [2];
    logic                r_pwm_l;
    logic                r_pwm_r;

    logic                w_wrap;
    logic                w_tick;
    logic [PWM_BITS:0]   w_target [2];
    logic [PWM_BITS:0]   w_target_nxt [2];
    logic [PWM_BITS:0]   w_duty_nxt [2];
    wheel_state_t        w_state_nxt [2];

    assign w_wrap = (r_cnt == CNT_LAST);
    assign w_tick = w_wrap && (r_div == DIV_LAST);

    // Targets from the captured command (ramp, status) and from the command
    // being captured this edge (state, so state stays consistent with cmd_q).
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            w_target[i]     = r_cmd_q[i]   ? DMAX : '0;
            w_target_nxt[i] = wheel_cmd[i] ? DMAX : '0;
        end
    end

    // Ramp each duty one step towards its target on a tick, clamping at target.
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            w_duty_nxt[i] = r_duty[i];
            if (w_tick) begin
                if (r_duty[i] < w_target[i]) begin
                    w_duty_nxt[i] = (w_target[i] - r_duty[i] > STEP) ? r_duty[i] + STEP : w_target[i];
                end else if (r_duty[i] > w_target[i]) begin
                    w_duty_nxt[i] = (r_duty[i] - w_target[i] > STEP) ? r_duty[i] - STEP : w_target[i];
                end
            end
        end
    end

    // Per-wheel next state from the post-update duty and target; estop forces IDLE.
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            w_state_nxt[i] = r_state[i];
            case (r_state[i])
                IDLE: begin
                    if (w_duty_nxt[i] < w_target_nxt[i]) w_state_nxt[i] = ACCEL;
                end
                ACCEL, DECEL: begin
                    if (w_duty_nxt[i] == w_target_nxt[i])
                        w_state_nxt[i] = (w_target_nxt[i] == '0) ? IDLE : RUN;
                    else if (w_duty_nxt[i] < w_target_nxt[i])
                        w_state_nxt[i] = ACCEL;
                    else
                        w_state_nxt[i] = DECEL;
                end
                RUN: begin
                    if (w_duty_nxt[i] > w_target_nxt[i])      w_state_nxt[i] = DECEL;
                    else if (w_duty_nxt[i] < w_target_nxt[i]) w_state_nxt[i] = ACCEL;
                end
                default: w_state_nxt[i] = IDLE;
            endcase
            if (estop) w_state_nxt[i] = IDLE;
        end
    end

    // Timebase: PWM counter always runs; ramp divider restarts on estop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_div <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (estop) begin
                r_div <= '0;
            end else if (w_wrap) begin
                r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
            end
        end
    end

    // Command capture register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cmd_q <= '0;
        else     r_cmd_q <= wheel_cmd;
    end

    // Duty, FSM state and registered PWM outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_duty[i]  <= '0;
                r_state[i] <= IDLE;
            end
            r_pwm_l <= 1'b0;
            r_pwm_r <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_duty[i]  <= estop ? '0 : w_duty_nxt[i];
                r_state[i] <= w_state_nxt[i];
            end
            r_pwm_l <= !estop && ({1'b0, r_cnt} < r_duty[1]);
            r_pwm_r <= !estop && ({1'b0, r_cnt} < r_duty[0]);
        end
    end

    assign pwm_l      = r_pwm_l;
    assign pwm_r      = r_pwm_r;
    assign settled[1] = (r_duty[1] == w_target[1]);
    assign settled[0] = (r_duty[0] == w_target[0]);
    assign busy       = (r_state[1] == ACCEL) || (r_state[1] == DECEL) ||
                        (r_state[0] == ACCEL) || (r_state[0] == DECEL);

endmodule

// File: tb/tb_wheel_pwm_driver.sv
// tb_wheel_pwm_driver: directed checks of ramping, reversal, saturation,
// estop and async reset. Duty is observed as PWM high cycles per period.
module tb_wheel_pwm_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       estop;
    logic [1:0] wheel_cmd;
    logic       pwm_l, pwm_r, busy;
    logic [1:0] settled;
    logic       pwm_l2, pwm_r2, busy2;
    logic [1:0] settled2;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;
    int l, r, l2, r2;

    wheel_pwm_driver #(.PWM_BITS(4), .DUTY_MAX(12), .RAMP_STEP(4), .RAMP_DIV(1)) dut (
        .clk(clk), .rst(rst), .wheel_cmd(wheel_cmd), .estop(estop),
        .pwm_l(pwm_l), .pwm_r(pwm_r), .settled(settled), .busy(busy)
    );

    wheel_pwm_driver #(.PWM_BITS(4), .DUTY_MAX(10), .RAMP_STEP(4), .RAMP_DIV(1)) dut10 (
        .clk(clk), .rst(rst), .wheel_cmd(wheel_cmd), .estop(estop),
        .pwm_l(pwm_l2), .pwm_r(pwm_r2), .settled(settled2), .busy(busy2)
    );

    always #5 clk = ~clk;

    // Edges since reset release; a multiple of 16 marks a period boundary.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic wait_tick();
        int found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            @(negedge clk);
            if (cyc % 16 == 0) found = 1;
        end
        chk("tick_seen", found, 1);
    endtask

    // Counts high cycles over the 16 PWM samples following a period boundary.
    task automatic measure(output int ml, output int mr, output int ml2, output int mr2);
        ml = 0; mr = 0; ml2 = 0; mr2 = 0;
        repeat (16) begin
            @(posedge clk);
            @(negedge clk);
            ml  += int'(pwm_l);
            mr  += int'(pwm_r);
            ml2 += int'(pwm_l2);
            mr2 += int'(pwm_r2);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; wheel_cmd = 2'b00; estop = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pwm_l", pwm_l, 0);
        chk("rst_pwm_r", pwm_r, 0);
        chk("rst_settled", settled, 2'b11);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        // Ramp up from reset; the DUTY_MAX=10 build saturates at 10.
        wheel_cmd = 2'b11;
        #1 chk("cmd_settled_before", settled, 2'b11);
        @(negedge clk);
        chk("cmd_settled_drop", settled, 2'b00);
        chk("cmd_busy", busy, 1);
        chk("cmd_settled_drop10", settled2, 2'b00);
        wait_tick();
        measure(l, r, l2, r2);
        chk("up1_l", l, 4); chk("up1_r", r, 4); chk("up1_l10", l2, 4);
        measure(l, r, l2, r2);
        chk("up2_l", l, 8); chk("up2_r", r, 8); chk("up2_r10", r2, 8);
        measure(l, r, l2, r2);
        chk("up3_l", l, 12); chk("up3_r", r, 12); chk("up3_l10", l2, 10); chk("up3_r10", r2, 10);
        chk("up_settled", settled, 2'b11);
        chk("up_busy", busy, 0);
        chk("up_settled10", settled2, 2'b11);
        measure(l, r, l2, r2);
        chk("run_l", l, 12); chk("run_r10", r2, 10);

        // Left soft stop, right keeps running.
        wheel_cmd = 2'b01;
        measure(l, r, l2, r2);
        chk("dn0_l", l, 12); chk("dn0_r", r, 12);
        chk("dn_settled", settled, 2'b01);
        chk("dn_busy", busy, 1);
        measure(l, r, l2, r2);
        chk("dn1_l", l, 8); chk("dn1_r", r, 12);
        measure(l, r, l2, r2);
        chk("dn2_l", l, 4);
        chk("dn_settled_end", settled, 2'b11);
        chk("dn_busy_end", busy, 0);
        measure(l, r, l2, r2);
        chk("dn3_l", l, 0); chk("dn3_r", r, 12);

        // Reversal mid-ramp: accelerate to 8, then command off.
        wheel_cmd = 2'b11;
        measure(l, r, l2, r2);
        chk("rev0_l", l, 0);
        measure(l, r, l2, r2);
        chk("rev1_l", l, 4);
        chk("rev_busy", busy, 1);
        wheel_cmd = 2'b01;
        measure(l, r, l2, r2);
        chk("rev2_l", l, 8);
        measure(l, r, l2, r2);
        chk("rev3_l", l, 4);
        measure(l, r, l2, r2);
        chk("rev4_l", l, 0); chk("rev4_r", r, 12);
        chk("rev_settled", settled, 2'b11);
        chk("rev_busy_end", busy, 0);

        // Back to speed, then a one-cycle estop.
        wheel_cmd = 2'b11;
        repeat (4) measure(l, r, l2, r2);
        chk("pre_es_l", l, 12);
        repeat (4) @(negedge clk);
        chk("pre_es_pwm_l", pwm_l, 1);
        estop = 1'b1;
        @(negedge clk);
        chk("es_pwm_l", pwm_l, 0);
        chk("es_pwm_r", pwm_r, 0);
        chk("es_busy", busy, 0);
        chk("es_settled", settled, 2'b00);
        estop = 1'b0;
        @(negedge clk);
        chk("es_rel_busy", busy, 1);
        chk("es_rel_pwm_l", pwm_l, 0);
        wait_tick();
        measure(l, r, l2, r2);
        chk("es_up1_l", l, 4); chk("es_up1_r", r, 4);
        measure(l, r, l2, r2);
        chk("es_up2_l", l, 8);
        measure(l, r, l2, r2);
        chk("es_up3_l", l, 12); chk("es_up3_r", r, 12);

        // Async reset mid-period while both outputs are high.
        repeat (4) @(negedge clk);
        chk("pre_rst_pwm_r", pwm_r, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_pwm_l", pwm_l, 0);
        chk("mid_rst_pwm_r", pwm_r, 0);
        chk("mid_rst_pwm_l10", pwm_l2, 0);
        chk("mid_rst_settled", settled, 2'b11);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        wheel_cmd = 2'b00;
        rst = 1'b0;
        wait_tick();
        measure(l, r, l2, r2);
        chk("post_rst_l", l, 0); chk("post_rst_r", r, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
